// File: rtl/serial_word_adder.sv
// serial_word_adder
//   Bit-serial adder/subtractor for two LSB-first operand streams. Every
//   accepted bit produces one registered result bit a clock later. Each word's
//   add/sub mode is taken from `sub` on bit 0. The overflow flag and the
//   parallel word come out together with the word's MSB.
//
// Ports
//   clock, reset : rising-edge clock, synchronous active-high reset
//   in_valid     : line1/line2/sub carry a bit this cycle (0 = stall)
//   line1, line2 : operand A / operand B bit, LSB first
//   sub          : 1 = A-B, 0 = A+B; sampled only on bit 0 of a word
//   outp         : registered sum/difference bit
//   out_valid    : outp is valid this cycle
//   word_end     : outp is the MSB of a word
//   overflw      : overflow of the completed word (with word_end)
//   sum_word     : parallel result, updated with word_end
//   sum_valid    : one-cycle pulse coincident with word_end
module serial_word_adder #(
  parameter int WORD_BITS  = 4,
  parameter bit SIGNED_OVF = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 line1,
  input  logic                 line2,
  input  logic                 sub,
  output logic                 outp,
  output logic                 out_valid,
  output logic                 word_end,
  output logic                 overflw,
  output logic [WORD_BITS-1:0] sum_word,
  output logic                 sum_valid
);

  localparam int              IDX_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORD_BITS - 1);

  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 carry_q, carry_d;
  logic                 mode_q, mode_d;
  logic                 outp_q, outp_d;
  logic                 out_valid_q, out_valid_d;
  logic                 word_end_q, word_end_d;
  logic                 overflw_q, overflw_d;
  logic [WORD_BITS-1:0] sum_word_q, sum_word_d;
  logic                 sum_valid_q, sum_valid_d;
  logic [WORD_BITS-1:0] acc_q, acc_d;

  logic first_bit, last_bit, s_eff, b_eff, cin, sum, cout;

  always_comb begin
    first_bit = (bit_idx_q == '0);
    last_bit  = (bit_idx_q == LAST);
    // Mode comes live from `sub` on bit 0, afterwards from the latched copy.
    s_eff     = first_bit ? sub : mode_q;
    // Subtraction is A + ~B + 1: invert B and inject the +1 as carry-in on bit 0.
    b_eff     = line2 ^ s_eff;
    cin       = first_bit ? s_eff : carry_q;
    sum       = line1 ^ b_eff ^ cin;
    cout      = (line1 & b_eff) | (line1 & cin) | (b_eff & cin);

    bit_idx_d   = bit_idx_q;
    carry_d     = carry_q;
    mode_d      = mode_q;
    outp_d      = outp_q;
    out_valid_d = 1'b0;
    word_end_d  = 1'b0;
    overflw_d   = overflw_q;
    sum_word_d  = sum_word_q;
    sum_valid_d = 1'b0;
    acc_d       = acc_q;

    if (in_valid) begin
      outp_d      = sum;
      out_valid_d = 1'b1;
      mode_d      = s_eff;
      // New bit enters at the top; after WORD_BITS shifts the word is aligned.
      acc_d       = {sum, acc_q[WORD_BITS-1:1]};
      if (last_bit) begin
        word_end_d  = 1'b1;
        sum_valid_d = 1'b1;
        sum_word_d  = acc_d;
        if (SIGNED_OVF)
          overflw_d = cin ^ cout;
        else
          overflw_d = s_eff ? ~cout : cout;  // no carry out on sub means borrow
        carry_d     = 1'b0;
        bit_idx_d   = '0;
      end else begin
        overflw_d   = 1'b0;
        carry_d     = cout;
        bit_idx_d   = bit_idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_idx_q   <= '0;
      carry_q     <= 1'b0;
      mode_q      <= 1'b0;
      outp_q      <= 1'b0;
      out_valid_q <= 1'b0;
      word_end_q  <= 1'b0;
      overflw_q   <= 1'b0;
      sum_word_q  <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      bit_idx_q   <= bit_idx_d;
      carry_q     <= carry_d;
      mode_q      <= mode_d;
      outp_q      <= outp_d;
      out_valid_q <= out_valid_d;
      word_end_q  <= word_end_d;
      overflw_q   <= overflw_d;
      sum_word_q  <= sum_word_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  // Shift register is pure data: any stale bits are shifted out by a full word.
  always_ff @(posedge clock) begin
    acc_q <= acc_d;
  end

  assign outp      = outp_q;
  assign out_valid = out_valid_q;
  assign word_end  = word_end_q;
  assign overflw   = overflw_q;
  assign sum_word  = sum_word_q;
  assign sum_valid = sum_valid_q;

endmodule

// File: tb/tb_serial_word_adder.sv
module tb_serial_word_adder;

  logic clock = 1'b0;
  logic reset, in_valid, line1, line2, sub;

  logic       u_outp, u_out_valid, u_word_end, u_overflw, u_sum_valid;
  logic [3:0] u_sum_word;
  logic       s_outp, s_out_valid, s_word_end, s_overflw, s_sum_valid;
  logic [3:0] s_sum_word;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  serial_word_adder #(.WORD_BITS(4), .SIGNED_OVF(1'b0)) u_uns (
    .clock(clock), .reset(reset), .in_valid(in_valid), .line1(line1), .line2(line2),
    .sub(sub), .outp(u_outp), .out_valid(u_out_valid), .word_end(u_word_end),
    .overflw(u_overflw), .sum_word(u_sum_word), .sum_valid(u_sum_valid));

  serial_word_adder #(.WORD_BITS(4), .SIGNED_OVF(1'b1)) u_sgn (
    .clock(clock), .reset(reset), .in_valid(in_valid), .line1(line1), .line2(line2),
    .sub(sub), .outp(s_outp), .out_valid(s_out_valid), .word_end(s_word_end),
    .overflw(s_overflw), .sum_word(s_sum_word), .sum_valid(s_sum_valid));

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sub;
    logic [3:0] sum;
    logic       ovf_u;
    logic       ovf_s;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one accepted bit, then check the registered result one edge later.
  task automatic bit_step(input logic [3:0] a, input logic [3:0] b, input logic s,
                          input int idx, input logic [3:0] exp_sum,
                          input logic ou, input logic os);
    in_valid = 1'b1;
    line1    = a[idx];
    line2    = b[idx];
    sub      = s;
    @(posedge clock); #1;
    chk("outp_u", u_outp, exp_sum[idx]);
    chk("outp_s", s_outp, exp_sum[idx]);
    chk("out_valid", u_out_valid, 1'b1);
    chk("word_end", u_word_end, idx == 3);
    chk("sum_valid", s_sum_valid, idx == 3);
    if (idx == 3) begin
      chk("sum_word_u", u_sum_word, exp_sum);
      chk("sum_word_s", s_sum_word, exp_sum);
      chk("overflw_u", u_overflw, ou);
      chk("overflw_s", s_overflw, os);
    end else begin
      chk("overflw_mid", u_overflw, 1'b0);
    end
  endtask

  task automatic stall(input logic held_outp, input logic [3:0] held_word);
    in_valid = 1'b0;
    line1    = 1'b1;
    line2    = 1'b1;
    sub      = 1'b1;
    @(posedge clock); #1;
    chk("stall_out_valid", u_out_valid, 1'b0);
    chk("stall_word_end", u_word_end, 1'b0);
    chk("stall_sum_valid", u_sum_valid, 1'b0);
    chk("stall_outp", u_outp, held_outp);
    chk("stall_sum_word", u_sum_word, held_word);
  endtask

  initial begin
    //          a      b      sub   sum    ovf_u ovf_s
    vecs[0] = '{4'd7,  4'd9,  1'b0, 4'h0,  1'b1, 1'b0};
    vecs[1] = '{4'd3,  4'd5,  1'b1, 4'hE,  1'b1, 1'b0};
    vecs[2] = '{4'd5,  4'd3,  1'b1, 4'h2,  1'b0, 1'b0};
    vecs[3] = '{4'd7,  4'd1,  1'b0, 4'h8,  1'b0, 1'b1};
    vecs[4] = '{4'd2,  4'd3,  1'b0, 4'h5,  1'b0, 1'b0};
    vecs[5] = '{4'd15, 4'd1,  1'b0, 4'h0,  1'b1, 1'b0};
    vecs[6] = '{4'd8,  4'd1,  1'b1, 4'h7,  1'b0, 1'b1};
    vecs[7] = '{4'd0,  4'd1,  1'b1, 4'hF,  1'b1, 1'b0};
    vecs[8] = '{4'd6,  4'd6,  1'b0, 4'hC,  1'b0, 1'b1};

    reset = 1'b1; in_valid = 1'b1; line1 = 1'b1; line2 = 1'b1; sub = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_outp", u_outp, 1'b0);
    chk("rst_out_valid", u_out_valid, 1'b0);
    chk("rst_word_end", s_word_end, 1'b0);
    chk("rst_overflw", u_overflw, 1'b0);
    chk("rst_sum_word", u_sum_word, 4'h0);
    chk("rst_sum_valid", u_sum_valid, 1'b0);
    reset = 1'b0;

    // Table words applied back-to-back with in_valid held high.
    foreach (vecs[k])
      for (int i = 0; i < 4; i++)
        bit_step(vecs[k].a, vecs[k].b, vecs[k].sub, i, vecs[k].sum,
                 vecs[k].ovf_u, vecs[k].ovf_s);

    // 6+6 with two-cycle stalls after bits 1 and 2; sub raised after bit 0.
    bit_step(4'd6, 4'd6, 1'b0, 0, 4'hC, 1'b0, 1'b1);
    bit_step(4'd6, 4'd6, 1'b1, 1, 4'hC, 1'b0, 1'b1);
    stall(1'b0, 4'hC);
    stall(1'b0, 4'hC);
    bit_step(4'd6, 4'd6, 1'b1, 2, 4'hC, 1'b0, 1'b1);
    stall(1'b1, 4'hC);
    stall(1'b1, 4'hC);
    bit_step(4'd6, 4'd6, 1'b1, 3, 4'hC, 1'b0, 1'b1);

    // Partial word 7+7, reset after bit 2, then 1+1 must start cleanly.
    for (int i = 0; i < 3; i++)
      bit_step(4'd7, 4'd7, 1'b0, i, 4'hE, 1'b0, 1'b1);
    reset = 1'b1; in_valid = 1'b1; line1 = 1'b1; line2 = 1'b1;
    @(posedge clock); #1;
    chk("midrst_outp", u_outp, 1'b0);
    chk("midrst_out_valid", u_out_valid, 1'b0);
    chk("midrst_word_end", u_word_end, 1'b0);
    chk("midrst_overflw", s_overflw, 1'b0);
    chk("midrst_sum_word", s_sum_word, 4'h0);
    chk("midrst_sum_valid", u_sum_valid, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++)
      bit_step(4'd1, 4'd1, 1'b0, i, 4'h2, 1'b0, 1'b0);

    in_valid = 1'b0;
    @(posedge clock); #1;
    chk("idle_out_valid", u_out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
